// File: rtl/display_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_mux
// Description : Time-multiplexes a NUM_DIGITS-digit hex value onto a single
//               shared 7-segment decoder. Each digit slot consists of a BLANK
//               phase (all anodes off, suppresses ghosting) followed by a SHOW
//               phase (one anode on, its nibble presented on BinOut).
//
// Parameters  : NUM_DIGITS   (>=2)  number of digits scanned
//               REFRESH_DIV  (>=1)  cycles a digit is lit
//               BLANK_CYCLES (>=0)  dark cycles before each digit
//
// Ports       : Clk        in   system clock, rising edge
//               Reset_n    in   asynchronous active-low reset
//               ValueIn    in   value to display, nibble k -> digit k
//               LoadIn     in   1-cycle strobe, captures ValueIn into shadow
//               DigitEnIn  in   per-digit enable (0 = dark)
//               BinOut     out  nibble for the downstream 7-segment decoder
//               AnodeOut   out  active-low digit selects (one-cold / all-ones)
//               DigitIdx   out  index of the digit owning the current slot
//
// Build option: LEADING_ZERO_BLANK_EN - when defined, digits above the most
//               significant non-zero nibble are forced dark (digit 0 always
//               shown). When undefined no zero-detect logic is built.
//
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic [4*NUM_DIGITS-1:0]       ValueIn,
    input  logic                          LoadIn,
    input  logic [NUM_DIGITS-1:0]         DigitEnIn,
    output logic [3:0]                    BinOut,
    output logic [NUM_DIGITS-1:0]         AnodeOut,
    output logic [$clog2(NUM_DIGITS)-1:0] DigitIdx
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [IDX_W-1:0] C_LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] C_SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
    // Only meaningful when BLANK_CYCLES > 0; the zero case is handled separately.
    localparam logic [CNT_W-1:0] C_BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
    localparam bit               C_NO_BLANK   = (BLANK_CYCLES == 0);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [IDX_W-1:0]          r_idx;
    logic [4*NUM_DIGITS-1:0]   r_shadow;
    logic [3:0]                r_bin;
    logic [NUM_DIGITS-1:0]     r_anode;

    // ------------------------------------------------------------------------
    // Combinational next-state signals
    // ------------------------------------------------------------------------
    state_t                    w_state_nxt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic [IDX_W-1:0]          w_idx_nxt;
    logic [IDX_W-1:0]          w_idx_inc;
    logic [IDX_W-1:0]          w_load_idx;
    logic                      w_load;
    logic                      w_all_off;
    logic                      w_dark;
    logic                      w_lz_dark;
    logic [NUM_DIGITS-1:0]     w_anode_load;
    logic [3:0]                w_bin_load;

    assign w_idx_inc = (r_idx == C_LAST_IDX) ? '0 : r_idx + 1'b1;

    // ------------------------------------------------------------------------
    // Shadow register: only a LoadIn strobe updates it, so the scanned value
    // is stable regardless of ValueIn activity.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_shadow <= '0;
        end else if (LoadIn) begin
            r_shadow <= ValueIn;
        end
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_load_idx  = r_idx;
        w_load      = 1'b0;
        w_all_off   = 1'b0;

        case (r_state)
            ST_BLANK: begin
                // With no blanking the state is only visited once after reset
                // and is left on the first edge.
                if (C_NO_BLANK || (r_cnt == C_BLANK_LAST)) begin
                    w_state_nxt = ST_SHOW;
                    w_cnt_nxt   = '0;
                    w_load      = 1'b1;
                end
            end
            ST_SHOW: begin
                if (r_cnt == C_SHOW_LAST) begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = w_idx_inc;
                    if (C_NO_BLANK) begin
                        // Back-to-back digits: load the next digit directly.
                        w_state_nxt = ST_SHOW;
                        w_load      = 1'b1;
                        w_load_idx  = w_idx_inc;
                    end else begin
                        w_state_nxt = ST_BLANK;
                        w_all_off   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Leading-zero suppression: digit k is dark when nibbles k..N-1 of the
    // shadow snapshot are all zero. Digit 0 is never suppressed.
    // ------------------------------------------------------------------------
`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] w_upper_zero;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lz
        if (k == 0) begin : g_lz_d0
            assign w_upper_zero[k] = 1'b0;
        end else begin : g_lz_dk
            assign w_upper_zero[k] = ~|r_shadow[4*NUM_DIGITS-1:4*k];
        end
    end

    assign w_lz_dark = w_upper_zero[w_load_idx];
`else
    assign w_lz_dark = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Values loaded at the start of a SHOW phase. They read the shadow as it
    // stands before the edge, so a coincident LoadIn affects the next slot.
    // ------------------------------------------------------------------------
    assign w_dark     = ~DigitEnIn[w_load_idx] | w_lz_dark;
    assign w_bin_load = r_shadow[4*w_load_idx +: 4];

    always_comb begin
        w_anode_load             = '1;
        w_anode_load[w_load_idx] = w_dark;
    end

    // ------------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_bin   <= 4'h0;
            r_anode <= '1;
        end else if (w_load) begin
            r_bin   <= w_bin_load;
            r_anode <= w_anode_load;
        end else if (w_all_off) begin
            r_anode <= '1;
        end
    end

    assign BinOut   = r_bin;
    assign AnodeOut = r_anode;
    assign DigitIdx = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_mux
// Description : Directed self-checking bench for display_scan_mux with
//               NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1 (slot = 5 cycles,
//               frame = 20 cycles). Cycle n means sampled 1 time unit after
//               the n-th rising edge following reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_mux;

    logic        Clk;
    logic        Reset_n;
    logic [15:0] ValueIn;
    logic        LoadIn;
    logic [3:0]  DigitEnIn;
    logic [3:0]  BinOut;
    logic [3:0]  AnodeOut;
    logic [1:0]  DigitIdx;

    int checks   = 0;
    int failures = 0;

    display_scan_mux #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (1)
    ) u_dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .ValueIn   (ValueIn),
        .LoadIn    (LoadIn),
        .DigitEnIn (DigitEnIn),
        .BinOut    (BinOut),
        .AnodeOut  (AnodeOut),
        .DigitIdx  (DigitIdx)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // LoadIn is a one-cycle strobe: it is cleared after every edge.
    task automatic tick();
        @(posedge Clk);
        #1;
        LoadIn = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] an,
                           input logic [3:0] bin, input logic [1:0] idx);
        chk({tag, ".anode"}, AnodeOut, an);
        chk({tag, ".bin"},   BinOut,   bin);
        chk({tag, ".idx"},   {2'b00, DigitIdx}, {2'b00, idx});
    endtask

    // One blank cycle for the upcoming digit.
    task automatic blank_tick(input string tag, input logic [1:0] idx);
        tick();
        chk({tag, ".blank.anode"}, AnodeOut, 4'b1111);
        chk({tag, ".blank.idx"},   {2'b00, DigitIdx}, {2'b00, idx});
    endtask

    // n SHOW cycles with constant expected outputs.
    task automatic show_ticks(input string tag, input int n, input logic [3:0] an,
                              input logic [3:0] bin, input logic [1:0] idx);
        for (int i = 0; i < n; i++) begin
            tick();
            chk_all(tag, an, bin, idx);
        end
    endtask

    task automatic slot(input string tag, input logic [1:0] idx,
                        input logic [3:0] an, input logic [3:0] bin);
        blank_tick(tag, idx);
        show_ticks(tag, 4, an, bin, idx);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
    endtask

    initial begin
        Reset_n   = 1'b0;
        ValueIn   = 16'h0000;
        LoadIn    = 1'b0;
        DigitEnIn = 4'hF;

        // ---- Test 1: reset and first digit ----
        do_reset();
        chk_all("rst.c0", 4'b1111, 4'h0, 2'd0);
        tick();
        chk_all("rst.c1", 4'b1110, 4'h0, 2'd0);

        // ---- Test 2: scan of 1A2F, loaded mid-slot of digit 0 ----
        tick();                                   // cycle 2
        ValueIn = 16'h1A2F;
        LoadIn  = 1'b1;                           // captured at edge 3
        show_ticks("scan.d0old", 2, 4'b1110, 4'h0, 2'd0);  // cycles 3,4: no glitch
        slot("scan.d1", 2'd1, 4'b1101, 4'h2);
        slot("scan.d2", 2'd2, 4'b1011, 4'hA);
        slot("scan.d3", 2'd3, 4'b0111, 4'h1);
        slot("scan.wrap", 2'd0, 4'b1110, 4'hF);   // ends cycle 24

        // ---- Test 3: LoadIn on BLANK->SHOW edge of digit 2 ----
        slot("col.d1", 2'd1, 4'b1101, 4'h2);
        blank_tick("col.d2", 2'd2);               // cycle 30
        ValueIn = 16'h5555;
        LoadIn  = 1'b1;                           // captured at edge 31
        show_ticks("col.d2old", 4, 4'b1011, 4'hA, 2'd2);
        slot("col.d3", 2'd3, 4'b0111, 4'h5);
        slot("col.d0", 2'd0, 4'b1110, 4'h5);      // ends cycle 44

        // ---- Test 4: digit 2 disabled ----
        DigitEnIn = 4'b1011;
        slot("en.d1", 2'd1, 4'b1101, 4'h5);
        slot("en.d2", 2'd2, 4'b1111, 4'h5);       // 5 dark cycles
        slot("en.d3", 2'd3, 4'b0111, 4'h5);       // timing unchanged
        DigitEnIn = 4'hF;

        // ---- Test 5: async reset mid-SHOW of digit 2 ----
        slot("ar.d0", 2'd0, 4'b1110, 4'h5);
        slot("ar.d1", 2'd1, 4'b1101, 4'h5);
        blank_tick("ar.d2", 2'd2);
        show_ticks("ar.d2", 2, 4'b1011, 4'h5, 2'd2);
        Reset_n = 1'b0;
        #1;
        chk_all("ar.async", 4'b1111, 4'h0, 2'd0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        chk_all("ar.c0", 4'b1111, 4'h0, 2'd0);
        tick();
        chk_all("ar.c1", 4'b1110, 4'h0, 2'd0);

        // ---- Test 6: leading zeros, value 0030 then 0 ----
        ValueIn = 16'h0030;
        LoadIn  = 1'b1;                           // captured at edge 2
        show_ticks("lz.d0", 3, 4'b1110, 4'h0, 2'd0);
        slot("lz.d1", 2'd1, 4'b1101, 4'h3);
`ifdef LEADING_ZERO_BLANK_EN
        slot("lz.d2", 2'd2, 4'b1111, 4'h0);
        slot("lz.d3", 2'd3, 4'b1111, 4'h0);
`else
        slot("lz.d2", 2'd2, 4'b1011, 4'h0);
        slot("lz.d3", 2'd3, 4'b0111, 4'h0);
`endif
        blank_tick("lz.d0b", 2'd0);
        tick();
        chk_all("lz.d0b", 4'b1110, 4'h0, 2'd0);
        ValueIn = 16'h0000;
        LoadIn  = 1'b1;                           // mid-slot of digit 0
        show_ticks("lz0.d0", 3, 4'b1110, 4'h0, 2'd0);
`ifdef LEADING_ZERO_BLANK_EN
        slot("lz0.d1", 2'd1, 4'b1111, 4'h0);
        slot("lz0.d2", 2'd2, 4'b1111, 4'h0);
        slot("lz0.d3", 2'd3, 4'b1111, 4'h0);
`else
        slot("lz0.d1", 2'd1, 4'b1101, 4'h0);
        slot("lz0.d2", 2'd2, 4'b1011, 4'h0);
        slot("lz0.d3", 2'd3, 4'b0111, 4'h0);
`endif
        slot("lz0.d0", 2'd0, 4'b1110, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
